hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, number of decode source read ports (1..4).
REQ-002 SHALL have parameter AW, default 4, register address width.
REQ-003 SHALL have parameter PC_ADDR, default 15, register address that is never forwarded or hazard-checked.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port d_valid  in  1  valid instruction present in Decode.
REQ-007 SHALL have port d_ra  in  NUM_RD*AW  packed Decode source addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port d_wa  in  AW  Decode destination address.
REQ-009 SHALL have port d_regwrite  in  1  Decode instruction writes the register file.
REQ-010 SHALL have port d_memtoreg  in  1  Decode instruction is a load.
REQ-011 SHALL have port e_branch_taken  in  1  branch resolved taken in Execute.
REQ-012 SHALL have port fwd_sel_e  out  NUM_RD*2  per-port Execute operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
REQ-013 SHALL have ports stall_f and stall_d  out  1 each, active-high; they hold PC and Fetch/Decode.
REQ-014 SHALL have ports flush_d and flush_e  out  1 each, active-high; they clear Fetch/Decode and Decode/Execute.

Function
REQ-015 SHALL keep an internal shadow pipeline of stages E, M, W, each holding {v, wa, rw, mtr}; E also holds NUM_RD source addresses.
REQ-016 SHALL advance every cycle: W<=M, M<=E; E<=Decode fields with v=d_valid when flush_e=0, else E.v<=0.
REQ-017 SHALL treat a stage as a write source only when v=1, rw=1 and wa!=PC_ADDR.
REQ-018 SHALL compute fwd_sel_e[i] combinationally from E state: 10 if E.ra[i] matches a write-source M.wa; else 01 if it matches a write-source W.wa; else 00; force 00 when E.v=0 or E.ra[i]=PC_ADDR.
REQ-019 SHALL give M priority over W when both match the same source address.
REQ-020 SHALL assert ldstall = d_valid & E write-source & E.mtr & (any d_ra[i]==E.wa with d_ra[i]!=PC_ADDR).
REQ-021 SHALL drive stall_f = stall_d = ldstall & ~e_branch_taken.
REQ-022 SHALL drive flush_d = e_branch_taken and flush_e = ldstall | e_branch_taken.
REQ-023 SHALL let a taken branch override a simultaneous load-use stall: no stall; Decode and Execute both flushed.
REQ-024 SHALL resolve a load-use hazard with exactly one bubble; the dependent instruction receives fwd_sel 01 in Execute on the following cycle.
REQ-025 SHALL hold the Decode instruction during a stall; E receives the bubble; M/W continue to advance.

Reset
REQ-026 SHALL clear all stage v bits and all stored addresses and flags on reset.
REQ-027 SHALL drive fwd_sel_e=0, stall_f=0, stall_d=0, flush_d=0 and flush_e=0 on the cycle after reset is sampled and while reset is held, regardless of inputs.
REQ-028 SHALL discard all in-flight shadow state when reset is asserted mid-operation; there is no forwarding from pre-reset instructions.

Configuration
REQ-029 SHALL, with macro HAZARD_PERF_CNT_EN defined, add outputs stall_cnt and flush_cnt (32 bits each, out). They count cycles with stall_d=1 and with flush_e=1, saturate at 0xFFFFFFFF, and reset to 0.
REQ-030 SHALL, without HAZARD_PERF_CNT_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-031 SHALL cover: ADD R1 then ADD R2,R1,R3 back-to-back -> fwd_sel_e[1:0]=10 on the second instruction's Execute cycle, and no stall.
REQ-032 SHALL cover: write R4, one unrelated instruction, then read R4 on port 1 -> fwd_sel_e[3:2]=01.
REQ-033 SHALL cover: LDR R5 then ADD R6,R5,R5 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_sel_e=0101.
REQ-034 SHALL cover: LDR R5 in E, dependent instruction in D, with e_branch_taken=1 in the same cycle -> stall_d=0, flush_d=1, flush_e=1.
REQ-035 SHALL cover: an instruction writing R15 followed by a read of R15 -> fwd_sel_e=00, no stall.
REQ-036 SHALL cover: reset asserted with a load in E -> all outputs 0 next cycle; the next dependent read after reset gives fwd_sel 00. With HAZARD_PERF_CNT_EN, 3 load-use stalls give stall_cnt=3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows E/M/W to derive Execute forwarding selects and load-use stall/flush.
// Optional perf counters stall_cnt/flush_cnt are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned AW      = 4,
    parameter int unsigned PC_ADDR = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [NUM_RD*AW-1:0] d_ra,
    input  logic [AW-1:0]        d_wa,
    input  logic                 d_regwrite,
    input  logic                 d_memtoreg,
    input  logic                 e_branch_taken,
    output logic [NUM_RD*2-1:0]  fwd_sel_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    localparam logic [AW-1:0] PcReg = AW'(PC_ADDR);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] wa;
        logic          rw;
        logic          mtr;
    } stage_t;

    stage_t               e_q, m_q, w_q;
    logic [NUM_RD*AW-1:0] e_ra_q;
    logic                 reset_q;

    logic quiet;
    logic e_src, m_src, w_src;
    logic raw_hit, ldstall;

    // Outputs are held idle while reset is applied and for the cycle right after it.
    assign quiet = reset | reset_q;

    assign e_src = e_q.v & e_q.rw & (e_q.wa != PcReg);
    assign m_src = m_q.v & m_q.rw & (m_q.wa != PcReg);
    assign w_src = w_q.v & w_q.rw & (w_q.wa != PcReg);

    always_comb begin
        fwd_sel_e = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!quiet && e_q.v && (e_ra_q[i*AW +: AW] != PcReg)) begin
                if (m_src && (e_ra_q[i*AW +: AW] == m_q.wa)) begin
                    fwd_sel_e[i*2 +: 2] = 2'b10;
                end else if (w_src && (e_ra_q[i*AW +: AW] == w_q.wa)) begin
                    fwd_sel_e[i*2 +: 2] = 2'b01;
                end
            end
        end
    end

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ((d_ra[i*AW +: AW] == e_q.wa) && (d_ra[i*AW +: AW] != PcReg)) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign ldstall = d_valid & e_src & e_q.mtr & raw_hit;

    always_comb begin
        stall_f = ldstall & ~e_branch_taken & ~quiet;
        stall_d = ldstall & ~e_branch_taken & ~quiet;
        flush_d = e_branch_taken & ~quiet;
        flush_e = (ldstall | e_branch_taken) & ~quiet;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_ra_q  <= '0;
            reset_q <= 1'b1;
        end else begin
            reset_q <= 1'b0;
            w_q     <= m_q;
            m_q     <= e_q;
            e_q     <= '{v: d_valid & ~flush_e, wa: d_wa, rw: d_regwrite, mtr: d_memtoreg};
            e_ra_q  <= d_ra;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (flush_e && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus random traffic
// checked every cycle against an instruction-queue reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [7:0] d_ra;
    logic [3:0] d_wa;
    logic       d_regwrite;
    logic       d_memtoreg;
    logic       e_branch_taken;
    logic [3:0] fwd_sel_e;
    logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .d_valid        (d_valid),
        .d_ra           (d_ra),
        .d_wa           (d_wa),
        .d_regwrite     (d_regwrite),
        .d_memtoreg     (d_memtoreg),
        .e_branch_taken (e_branch_taken),
        .fwd_sel_e      (fwd_sel_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    typedef struct {
        bit       v;
        bit [3:0] wa;
        bit       rw;
        bit       mtr;
        bit [7:0] ra;
    } instr_t;

    // pipe[0] = Execute, pipe[1] = Memory, pipe[2] = Writeback
    instr_t pipe[$];
    bit     rst_seen;
    bit     exp_stall, exp_flush_d, exp_flush_e;
    bit [3:0] exp_fwd;
    int     n_checks = 0;
    int     n_fail   = 0;
    int unsigned exp_stall_cnt = 0, exp_flush_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(input instr_t s);
        return s.v && s.rw && (s.wa != 4'd15);
    endfunction

    task automatic model_check();
        instr_t e, m, w;
        bit quiet, hit, ld;
        bit [3:0] a;
        e = pipe[0];
        m = pipe[1];
        w = pipe[2];
        quiet   = reset || rst_seen;
        exp_fwd = '0;
        hit     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = e.ra[i*4 +: 4];
            if (e.v && a != 4'd15) begin
                if (writes(m) && m.wa == a)      exp_fwd[i*2 +: 2] = 2'b10;
                else if (writes(w) && w.wa == a) exp_fwd[i*2 +: 2] = 2'b01;
            end
            a = d_ra[i*4 +: 4];
            if (a == e.wa && a != 4'd15) hit = 1'b1;
        end
        ld = d_valid && writes(e) && e.mtr && hit;
        if (quiet) begin
            exp_fwd = '0;
            ld = 1'b0;
        end
        exp_stall   = ld && !e_branch_taken && !quiet;
        exp_flush_d = e_branch_taken && !quiet;
        exp_flush_e = (ld || e_branch_taken) && !quiet;
        check_eq("fwd_sel_e", 32'(fwd_sel_e), 32'(exp_fwd));
        check_eq("stall_f", 32'(stall_f), 32'(exp_stall));
        check_eq("stall_d", 32'(stall_d), 32'(exp_stall));
        check_eq("flush_d", 32'(flush_d), 32'(exp_flush_d));
        check_eq("flush_e", 32'(flush_e), 32'(exp_flush_e));
    endtask

    task automatic model_step();
        instr_t n;
        if (reset) begin
            n = '{v: 0, wa: 0, rw: 0, mtr: 0, ra: 0};
            pipe = '{n, n, n};
            rst_seen = 1'b1;
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            if (exp_stall)   exp_stall_cnt++;
            if (exp_flush_e) exp_flush_cnt++;
            n = '{v: d_valid && !exp_flush_e, wa: d_wa, rw: d_regwrite, mtr: d_memtoreg, ra: d_ra};
            pipe.push_front(n);
            void'(pipe.pop_back());
            rst_seen = 1'b0;
        end
    endtask

    task automatic apply(input bit v, input bit [3:0] ra1, input bit [3:0] ra0,
                         input bit [3:0] wa, input bit rw, input bit mtr,
                         input bit br, input bit rst);
        @(negedge clk);
        d_valid        = v;
        d_ra           = {ra1, ra0};
        d_wa           = wa;
        d_regwrite     = rw;
        d_memtoreg     = mtr;
        e_branch_taken = br;
        reset          = rst;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic nop();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit [3:0] pool [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15};

    initial begin
        instr_t z;
        z = '{v: 0, wa: 0, rw: 0, mtr: 0, ra: 0};
        pipe = '{z, z, z};
        rst_seen = 1'b0;

        apply(0, 0, 0, 0, 0, 0, 0, 1); tick();
        apply(1, 1, 1, 1, 1, 1, 1, 1);
        check_eq("reset_held_idle", 32'({fwd_sel_e, stall_d, flush_d, flush_e}), 32'd0);
        tick();
        nop(); tick();

        // ADD R1 ; ADD R2,R1,R3 -> ALUOutM forward on port 0
        apply(1, 3, 2, 1, 1, 0, 0, 0); tick();
        apply(1, 3, 1, 2, 1, 0, 0, 0);
        check_eq("b2b_no_stall", 32'(stall_d), 32'd0);
        tick();
        nop();
        check_eq("b2b_fwd_m", 32'(fwd_sel_e[1:0]), 32'd2);
        tick();

        // write R4, unrelated, read R4 on port 1 -> ResultW forward
        apply(1, 2, 3, 4, 1, 0, 0, 0); tick();
        apply(1, 2, 3, 7, 1, 0, 0, 0); tick();
        apply(1, 4, 0, 8, 1, 0, 0, 0); tick();
        nop();
        check_eq("w_fwd_port1", 32'(fwd_sel_e[3:2]), 32'd1);
        tick();
        nop(); tick(); nop(); tick();

        // LDR R5 ; ADD R6,R5,R5 -> one bubble then ResultW forward on both ports
        apply(1, 0, 1, 5, 1, 1, 0, 0); tick();
        apply(1, 5, 5, 6, 1, 0, 0, 0);
        check_eq("ld_stall_f", 32'(stall_f), 32'd1);
        check_eq("ld_stall_flush_e", 32'({stall_d, flush_e}), 32'd3);
        tick();
        apply(1, 5, 5, 6, 1, 0, 0, 0);
        check_eq("ld_stall_once", 32'(stall_d), 32'd0);
        tick();
        nop();
        check_eq("ld_fwd_w", 32'(fwd_sel_e), 32'b0101);
        tick();

        // load-use with simultaneous taken branch: branch wins
        apply(1, 0, 1, 5, 1, 1, 0, 0); tick();
        apply(1, 5, 5, 6, 1, 0, 1, 0);
        check_eq("br_over_ld", 32'({stall_d, flush_d, flush_e}), 32'b011);
        tick();
        nop(); tick();

        // R15 is never forwarded nor stalled on
        apply(1, 0, 0, 15, 1, 1, 0, 0); tick();
        apply(1, 15, 15, 6, 1, 0, 0, 0);
        check_eq("pc_no_stall", 32'(stall_d), 32'd0);
        tick();
        nop();
        check_eq("pc_no_fwd", 32'(fwd_sel_e), 32'd0);
        tick();

        // reset with a load in E discards it
        apply(1, 0, 1, 5, 1, 1, 0, 0); tick();
        apply(1, 5, 5, 6, 1, 0, 0, 1); tick();
        apply(1, 5, 5, 6, 1, 0, 1, 0);
        check_eq("post_reset_idle", 32'({fwd_sel_e, stall_d, flush_d, flush_e}), 32'd0);
        tick();
        nop();
        check_eq("post_reset_fwd", 32'(fwd_sel_e), 32'd0);
        tick();

`ifdef HAZARD_PERF_CNT_EN
        apply(0, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 1, 5, 1, 1, 0, 0); tick();
            apply(1, 5, 0, 6, 1, 0, 0, 0); tick();
            apply(1, 5, 0, 6, 1, 0, 0, 0); tick();
        end
        nop();
        check_eq("stall_cnt3", stall_cnt, 32'd3);
        tick();
`endif

        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                  pool[$urandom_range(0, 5)], $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0);
`ifdef HAZARD_PERF_CNT_EN
            check_eq("stall_cnt", stall_cnt, exp_stall_cnt);
            check_eq("flush_cnt", flush_cnt, exp_flush_cnt);
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
